acc_arbiter: RTL and testbench

- Shares the single accumulator register between NREQ requesters (core writeback, IO port, debug port, etc.).
- Arbitrates round-robin, latches the winner's data, drives the accumulator's enable and data inputs for exactly one cycle, then returns an ack and that write's zero flag to the winner.
- Sits between the requesters and the accumulator. It is the only driver of the accumulator's en/in inputs.

---
 rtl/acc_arb_pkg.sv | 9 +
 rtl/acc_arbiter_rr_pick.sv | 21 ++
 rtl/acc_arbiter.sv | 75 +++++++
 tb/tb_acc_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/acc_arb_pkg.sv
// acc_arb_pkg: shared FSM encoding and default data width for the accumulator arbiter.
package acc_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;
    localparam int ACC_W_DEFAULT = 8;
endpackage

// File: rtl/acc_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            valid
);
    logic [NREQ-1:0] w_rot;
    int              w_pos;
    always_comb begin
        w_rot = '0;
        w_pos = 0;
        for (int i = 0; i < NREQ; i++) w_rot[i] = req[(i + int'(ptr)) % NREQ];
        for (int i = NREQ - 1; i >= 0; i--) if (w_rot[i]) w_pos = i;
        idx = IDXW'((w_pos + int'(ptr)) % NREQ);
    end
    assign valid = |req;
endmodule

// File: rtl/acc_arbiter.sv
// acc_arbiter: shares one accumulator among NREQ requesters (IDLE -> WRITE -> ACK).
// Define ACC_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module acc_arbiter
    import acc_arb_pkg::*;
#(
    parameter int WIDTH = ACC_W_DEFAULT,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  z_ret,
    output logic                  busy,
    output logic                  acc_en,
    output logic [WIDTH-1:0]      acc_in,
    input  logic                  acc_z
);
    localparam int IDXW = $clog2(NREQ);
    state_t           r_state, w_next;
    logic [IDXW-1:0]  r_k, w_ptr, w_idx;
    logic             w_valid;
    logic [NREQ-1:0]  r_gnt;
    logic [WIDTH-1:0] r_acc_in;
`ifdef ACC_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDXW-1:0] r_ptr;
    // Pointer advances past the winner when its write completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= '0;
        else if (r_state == ST_ACK) r_ptr <= (r_k == IDXW'(NREQ - 1)) ? '0 : r_k + 1'b1;
    end
    assign w_ptr = r_ptr;
`endif
    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req  (req),
        .ptr  (w_ptr),
        .idx  (w_idx),
        .valid(w_valid)
    );
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next = w_valid ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_next = ST_ACK;
            default:  w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_gnt    <= '0;
            r_acc_in <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_valid) begin
                r_k      <= w_idx;
                r_gnt    <= NREQ'(1) << w_idx;
                r_acc_in <= wdata[w_idx*WIDTH +: WIDTH];
            end else if (r_state == ST_ACK) begin
                r_gnt <= '0;
            end
        end
    end
    assign gnt    = r_gnt;
    assign ack    = (r_state == ST_ACK) ? r_gnt : '0;
    assign z_ret  = (r_state == ST_ACK) & acc_z;
    assign busy   = r_state != ST_IDLE;
    assign acc_en = r_state == ST_WRITE;
    assign acc_in = r_acc_in;
endmodule

// File: tb/tb_acc_arbiter.sv
// tb_acc_arbiter: directed plus randomized checks of acc_arbiter against a transaction-level model.
module tb_acc_arbiter;
    localparam int W = 8;
    localparam int N = 4;
    logic           clk = 0;
    logic           rst_n = 0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt, ack;
    logic           z_ret, busy, acc_en, acc_z;
    logic [W-1:0]   acc_in;
    logic [W-1:0]   acc = 8'hFF;
    int total = 0;
    int bad = 0;
    int m_ptr = 0;

    acc_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
        .z_ret(z_ret), .busy(busy), .acc_en(acc_en), .acc_in(acc_in), .acc_z(acc_z)
    );

    always #5 clk = ~clk;
    // Accumulator model driven by the arbiter
    always @(posedge clk) if (acc_en) acc <= acc_in;
    assign acc_z = (acc == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [N-1:0] rq);
        for (int j = 0; j < N; j++) if (rq[(m_ptr + j) % N]) return (m_ptr + j) % N;
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; drives one request pattern through to idle again
    task automatic txn(input logic [N-1:0] rq, input logic [N*W-1:0] wd, input bit chg, input bit drop);
        int k;
        logic [W-1:0] d;
        logic [N-1:0] oh;
        req = rq;
        wdata = wd;
        k = winner(rq);
        if (k < 0) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_gnt", 32'(gnt), 0);
            return;
        end
        d = wd[k*W +: W];
        oh = N'(1) << k;
        @(negedge clk);
        chk("wr_gnt", 32'(gnt), 32'(oh));
        chk("wr_en", 32'(acc_en), 1);
        chk("wr_data", 32'(acc_in), 32'(d));
        chk("wr_ack", 32'(ack), 0);
        chk("wr_busy", 32'(busy), 1);
        if (chg) wdata = {$urandom, $urandom};
        if (drop) req[k] = 1'b0;
        @(negedge clk);
        chk("ack_onehot", 32'(ack), 32'(oh));
        chk("ack_gnt", 32'(gnt), 32'(oh));
        chk("ack_z", 32'(z_ret), 32'(d == 0));
        chk("ack_en", 32'(acc_en), 0);
        chk("ack_acc", 32'(acc), 32'(d));
        req[k] = 1'b0;
`ifndef ACC_ARB_FIXED_PRIO_EN
        m_ptr = (k + 1) % N;
`endif
        @(negedge clk);
        chk("post_gnt", 32'(gnt), 0);
        chk("post_ack", 32'(ack), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_hold", 32'(acc_in), 32'(d));
    endtask

    initial begin
        logic [W-1:0] saved;
        req = 4'b1111;
        wdata = {$urandom};
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_en", 32'(acc_en), 0);
        chk("rst_in", 32'(acc_in), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1;
        txn(4'b1111, 32'h44332211, 0, 0);
        txn(4'b0100, 32'h005A0000, 0, 0);
        txn(4'b0010, 32'hFFFF00FF, 0, 0);
        m_ptr = m_ptr;
        // Data change during WRITE must not reach the accumulator
        txn(4'b0001, 32'h00000011, 1, 0);
        // Reset during WRITE: write lost, pointer back to 0
        req = 4'b1111;
        wdata = 32'hA1B2C3D4;
        @(negedge clk);
        chk("mw_en", 32'(acc_en), 1);
        saved = acc;
        rst_n = 0;
        #1;
        chk("mw_rst_en", 32'(acc_en), 0);
        chk("mw_rst_gnt", 32'(gnt), 0);
        @(negedge clk);
        chk("mw_acc", 32'(acc), 32'(saved));
        chk("mw_ack", 32'(ack), 0);
        rst_n = 1;
        m_ptr = 0;
        for (int i = 0; i < 5; i++) txn(4'b1111, {$urandom}, 0, 0);
        for (int i = 0; i < 200; i++)
            txn(N'($urandom), ($urandom_range(0, 3) == 0) ? 32'h00000000 : {$urandom},
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
